// File: rtl/gate_event_logger_pkg.sv
// gate_event_pkg: shared widths, bit positions, event record and status states
// for gate_event_logger.
package gate_event_pkg;

    localparam int VEC_W    = 5;
    localparam int DEF_TS_W = 8;

    localparam int T_BIT = 4;
    localparam int N_BIT = 3;
    localparam int R_BIT = 2;
    localparam int K_BIT = 1;
    localparam int M_BIT = 0;

    typedef struct packed {
        logic [VEC_W-1:0]    vec;
        logic [DEF_TS_W-1:0] ts;
    } event_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FULL,
        DRAIN
    } state_t;

endpackage

// File: rtl/gate_event_logger_fifo.sv
// gate_event_fifo: synchronous first-word-fall-through FIFO; the head entry is
// presented on dout the cycle after it is written.
module gate_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/gate_event_logger.sv
// gate_event_logger: samples {t,n,r,k,m}, queues timestamped changes and counts
// t rising edges. Define GATE_EVENT_LOGGER_FILTER_EN to require two matching samples.
module gate_event_logger
    import gate_event_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             t,
    input  logic             n,
    input  logic             r,
    input  logic             k,
    input  logic             m,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [VEC_W-1:0] ev_data,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] t_rise_cnt,
    output logic             ovf
);

    logic [VEC_W-1:0]      vec;
    logic [VEC_W-1:0]      s_q, s_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    state_t                state_q, state_d;
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [VEC_W+TS_W-1:0] fifo_dout;
`ifdef GATE_EVENT_LOGGER_FILTER_EN
    logic [VEC_W-1:0]      cand_q, cand_d;
    logic                  cand_vld_q, cand_vld_d;
`endif

    assign vec = {t, n, r, k, m};
    assign pop = ev_ready && !fifo_empty;

    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        ts_d   = ts_q + TS_W'(1);
        accept = 1'b0;
`ifdef GATE_EVENT_LOGGER_FILTER_EN
        cand_d     = cand_q;
        cand_vld_d = 1'b0;
        if (en && (vec != s_q)) begin
            if (cand_vld_q && (vec == cand_q)) begin
                accept = 1'b1;
            end else begin
                cand_d     = vec;
                cand_vld_d = 1'b1;
            end
        end
`else
        accept = en && (vec != s_q);
`endif
        // The sample register tracks accepted vectors even when the FIFO drops them.
        if (accept) begin
            s_d = vec;
            if (vec[T_BIT] && !s_q[T_BIT] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            if (fifo_full && !pop) ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fifo_full)       state_d = FULL;
        else if (en)         state_d = RUN;
        else if (fifo_empty) state_d = IDLE;
        else                 state_d = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            s_q     <= s_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

`ifdef GATE_EVENT_LOGGER_FILTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
        end
    end
`endif

    gate_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VEC_W + TS_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({vec, ts_q}),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign ev_valid          = !fifo_empty;
    assign {ev_data, ev_ts}  = fifo_empty ? '0 : fifo_dout;
    assign t_rise_cnt        = cnt_q;
    assign ovf               = ovf_q;

endmodule

// File: tb/tb_gate_event_logger.sv
// Self-checking bench for gate_event_logger: a behavioural model feeds a scoreboard
// queue of expected events that is compared against the DUT head every cycle.
module tb_gate_event_logger;
    import gate_event_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        t, n, r, k, m;
    logic        ev_valid;
    logic        ev_ready;
    logic [4:0]  ev_data;
    logic [7:0]  ev_ts;
    logic [15:0] t_rise_cnt;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    event_t      sb[$];
    logic [4:0]  sM;
    logic [7:0]  tsM;
    logic [15:0] cntM;
    logic        ovfM;
`ifdef GATE_EVENT_LOGGER_FILTER_EN
    logic [4:0]  candM;
    logic        candVldM;
`endif

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  v;
        logic        ready;
        logic        expValid;
        logic [15:0] expCnt;
    } row_t;

    row_t tbl[15];

    always #5 clk = ~clk;

    gate_event_logger #(
        .DEPTH (DEPTH),
        .TS_W  (8),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .t          (t),
        .n          (n),
        .r          (r),
        .k          (k),
        .m          (m),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .ev_ts      (ev_ts),
        .t_rise_cnt (t_rise_cnt),
        .ovf        (ovf)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge: compare outputs against the model, drive the
    // new inputs, then advance the model to what the next rising edge does.
    task automatic applyStimulus(input logic rstV, input logic enV, input logic [4:0] vV, input logic readyV);
        logic   accept;
        event_t e;
        checkOutput("ev_valid", ev_valid, 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            checkOutput("ev_data", ev_data, sb[0].vec);
            checkOutput("ev_ts", ev_ts, sb[0].ts);
        end
        checkOutput("t_rise_cnt", t_rise_cnt, cntM);
        checkOutput("ovf", ovf, ovfM);

        rst = rstV;
        en = enV;
        {t, n, r, k, m} = vV;
        ev_ready = readyV;

        if (rstV) begin
            sb.delete();
            sM = '0;
            tsM = '0;
            cntM = '0;
            ovfM = 1'b0;
`ifdef GATE_EVENT_LOGGER_FILTER_EN
            candVldM = 1'b0;
`endif
        end else begin
            if (readyV && sb.size() > 0) void'(sb.pop_front());
`ifdef GATE_EVENT_LOGGER_FILTER_EN
            accept = 1'b0;
            if (enV && vV != sM) begin
                if (candVldM && vV == candM) begin
                    accept = 1'b1;
                    candVldM = 1'b0;
                end else begin
                    candM = vV;
                    candVldM = 1'b1;
                end
            end else begin
                candVldM = 1'b0;
            end
`else
            accept = enV && (vV != sM);
`endif
            if (accept) begin
                if (vV[4] && !sM[4] && cntM != 16'hFFFF) cntM = cntM + 16'd1;
                e.vec = vV;
                e.ts = tsM;
                if (sb.size() < DEPTH) sb.push_back(e);
                else ovfM = 1'b1;
                sM = vV;
            end
            tsM = tsM + 8'd1;
        end
    endtask

    task automatic cycle(input logic rstV, input logic enV, input logic [4:0] vV, input logic readyV);
        @(negedge clk);
        applyStimulus(rstV, enV, vV, readyV);
    endtask

    task automatic change(input logic [4:0] vV, input logic readyV);
        repeat (2) cycle(1'b0, 1'b1, vV, readyV);
    endtask

    task automatic checkState(input string name, input state_t exp);
        checkOutput(name, 32'(dut.state_q), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        {t, n, r, k, m} = 5'b0;
        ev_ready = 1'b0;
        sM = '0;
        tsM = '0;
        cntM = '0;
        ovfM = 1'b0;
`ifdef GATE_EVENT_LOGGER_FILTER_EN
        candM = '0;
        candVldM = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", ev_valid, 1'b0);
        checkOutput("rst_data", ev_data, 5'b0);
        checkOutput("rst_ts_out", ev_ts, 8'd0);
        checkOutput("rst_ts", dut.ts_q, 8'd0);
        checkState("rst_state", IDLE);

`ifndef GATE_EVENT_LOGGER_FILTER_EN
        tbl[0]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 5'b10000, 1'b1, 1'b0, 16'd0};
        tbl[11] = '{1'b0, 1'b1, 5'b10000, 1'b1, 1'b1, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 16'd1};
        tbl[13] = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b1, 16'd1};
        tbl[14] = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 16'd1};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].expValid);
            checkOutput($sformatf("tbl%0d_cnt", i), t_rise_cnt, tbl[i].expCnt);
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].ready);
        end
`else
        cycle(1'b0, 1'b1, 5'b00000, 1'b1);
        cycle(1'b0, 1'b1, 5'b01000, 1'b1);
        cycle(1'b0, 1'b1, 5'b00000, 1'b1);
        cycle(1'b0, 1'b1, 5'b00000, 1'b1);
        checkOutput("glitch_valid", ev_valid, 1'b0);
        cycle(1'b0, 1'b1, 5'b01000, 1'b1);
        cycle(1'b0, 1'b1, 5'b01000, 1'b1);
        cycle(1'b0, 1'b1, 5'b01000, 1'b1);
        cycle(1'b0, 1'b1, 5'b01000, 1'b1);
`endif

        // Stall with ready low, then drain in order.
        change(5'b00010, 1'b0);
        change(5'b00100, 1'b0);
        change(5'b01000, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 5'b01000, 1'b0);
        checkOutput("stall_head", ev_data, 5'b00010);
        repeat (5) cycle(1'b0, 1'b0, 5'b01000, 1'b1);

        // Overfill, then push together with a pop.
        cycle(1'b1, 1'b0, 5'b00000, 1'b0);
        for (int i = 1; i <= 9; i++) change(5'(i), 1'b0);
        cycle(1'b0, 1'b1, 5'd9, 1'b0);
        checkState("full_state", FULL);
        checkOutput("ovf_set", ovf, 1'b1);
        change(5'd20, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 5'd20, 1'b1);
        checkState("drained_state", IDLE);
        checkOutput("ovf_sticky", ovf, 1'b1);

        // Reset with events queued and an event in flight.
        change(5'b10000, 1'b0);
        change(5'b00001, 1'b0);
        change(5'b10001, 1'b0);
        change(5'b00010, 1'b0);
        cycle(1'b1, 1'b1, 5'b00111, 1'b1);
        cycle(1'b0, 1'b0, 5'b00000, 1'b0);
        checkOutput("post_rst_valid", ev_valid, 1'b0);
        checkOutput("post_rst_data", ev_data, 5'b0);
        checkOutput("post_rst_ts", dut.ts_q, 8'd0);
        checkOutput("post_rst_cnt", t_rise_cnt, 16'd0);
        checkOutput("post_rst_ovf", ovf, 1'b0);
        checkState("post_rst_state", IDLE);
        repeat (3) cycle(1'b0, 1'b0, 5'b00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_event_logger.md
Name: gate_event_logger

Overview:
- Registered downstream monitor for the combinational gate-logic stage.
- Samples that stage's five outputs {t,n,r,k,m} on a clock and detects changes in the sampled vector.
- Each change is queued as a timestamped event in a small FIFO, drained over a valid/ready handshake.
- Also keeps a saturating count of rising edges on t, plus a sticky overflow flag.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- TS_W, 8: timestamp width; the free-running counter wraps at 2^TS_W.
- CNT_W, 16: width of the t rising-edge counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sampling enable; inputs are examined only on cycles with en=1.
- t  input  1  gate-stage output t.
- n  input  1  gate-stage output n.
- r  input  1  gate-stage output r.
- k  input  1  gate-stage output k.
- m  input  1  gate-stage output m.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts the head event.
- ev_data  output  5  head event vector; bit4=t, 3=n, 2=r, 1=k, 0=m.
- ev_ts  output  TS_W  timestamp of the head event.
- t_rise_cnt  output  CNT_W  count of t 0→1 transitions seen on enabled samples.
- ovf  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge) forces all of the following; an in-flight event or pending pop is discarded:
  - sample register s_q=0; ts=0; FIFO empty.
  - ev_valid=0, ev_data=0, ev_ts=0, t_rise_cnt=0, ovf=0, state=IDLE.
- Timestamp: ts increments every cycle, independent of en, and wraps 2^TS_W-1 → 0.
- Event detect: on a cycle with en=1, let v={t,n,r,k,m}.
  - If v != s_q, push {v, ts} (the current ts value) and set s_q<=v.
  - If en=0, s_q holds and nothing is pushed.
  - The first enabled sample after reset pushes only if v != 0.
- t rise: on an enabled cycle with t=1 and s_q[4]=0, t_rise_cnt increments by 1, saturating at 2^CNT_W-1.
- Latency: an event pushed in cycle N is visible on ev_valid/ev_data/ev_ts in cycle N+1 (FIFO registered, FWFT).
- Handshake:
  - Pop occurs when ev_valid && ev_ready.
  - ev_data and ev_ts are held stable while ev_valid=1 && ev_ready=0.
  - ev_valid never drops without a pop.
  - Events are delivered in push order.
- Full FIFO:
  - Push with no simultaneous pop: the event is dropped, s_q still updates, and ovf<=1 until reset.
  - Push with a simultaneous pop: both are performed; no drop.
- Empty FIFO: ev_valid=0; ev_ready is ignored.
- State machine (status only; no effect on the datapath beyond the rules above):
  - IDLE: en=0 and FIFO empty.
  - RUN: en=1 and FIFO not full.
  - FULL: FIFO occupancy = DEPTH.
  - DRAIN: en=0 and FIFO not empty.
  - Transitions follow these conditions each cycle; FULL takes priority over RUN and DRAIN.
- Occupancy arithmetic: pointers are log2(DEPTH)+1 bits; full/empty are decided by wrap-bit compare.

Optional Feature:
- Macro: GATE_EVENT_LOGGER_FILTER_EN.
- Defined: a changed vector must be seen on 2 consecutive enabled samples with an identical value before it is pushed.
  - The push occurs on the second sample, with that cycle's ts.
  - A single-sample glitch produces no event and no t_rise_cnt increment.
  - A pending candidate is cleared by en=0 or by reset.
- Undefined: every change pushes immediately, as specified above.

Decomposition:
- Package gate_event_pkg:
  - VEC_W=5.
  - Bit index constants T_BIT=4, N_BIT=3, R_BIT=2, K_BIT=1, M_BIT=0.
  - Event struct typedef {vec[VEC_W], ts[TS_W]}.
  - State enum {IDLE, RUN, FULL, DRAIN}.
- One sub-module, gate_event_fifo: synchronous FWFT FIFO parameterised by DEPTH and entry width.
  - Ports: push/din/full and pop/dout/empty.

Test Plan:
- Reset then en=1 with v=00000 for 5 cycles → ev_valid stays 0; t_rise_cnt=0; ovf=0.
- en=1, v sequence 00000, 10000, 10000, 00001 starting at ts=3, ev_ready=1 → events {10000, ts=4} then {00001, ts=6}, each one cycle after its push; t_rise_cnt=1.
- ev_ready=0, push 3 events → ev_data/ev_ts stay on the first event; raising ev_ready drains all three in order, one per cycle.
- DEPTH=8, ev_ready=0, 9 changes → 8 entries, state=FULL, ovf=1; a 10th change pushed together with a pop → no loss; ovf stays 1.
- Assert rst while 4 events are queued and en=1 → next cycle ev_valid=0, ts=0, t_rise_cnt=0, ovf=0, state=IDLE.
- With GATE_EVENT_LOGGER_FILTER_EN: v=00000, 01000 for one sample, then 00000 → no event; v=01000 held 2 samples → one event carrying the second sample's ts.
